set_job_sched: RTL and testbench
================================

# set_job_sched

Job scheduler that shares one SET candidate-counting engine between two requesters. It arbitrates round-robin between the requesters and issues one job at a time over the engine's `en`/`busy`/`valid` handshake. Each result is returned tagged with the requester ID. An engine that never answers is covered by a timeout, and mode 3 jobs are rejected without reaching the engine. It sits between the job sources and the engine input.

## Interface
- `TIMEOUT`, default 256: maximum WAIT cycles allowed for `eng_valid`; must be ≥ 1.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous reset, active-high.
- `req0`, `req1` in 1: requester job requests; held until `ackN`.
- `central0`, `central1` in 24: job central field, stable while `reqN` is high.
- `radius0`, `radius1` in 12: job radius field, same rule.
- `mode0`, `mode1` in 2: job mode; 0/1/2 are valid, 3 is rejected.
- `ack0`, `ack1` out 1: one-cycle pulse; the job has been taken.
- `eng_busy` in 1: engine busy; low means the engine can accept `en`.
- `eng_en` out 1: one-cycle job strobe to the engine.
- `eng_central` out 24, `eng_radius` out 12, `eng_mode` out 2: registered job fields, stable from ISSUE until the next grant.
- `eng_valid` in 1: engine result strobe.
- `eng_candidate` in 8: engine result.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_id` out 1: requester of the response.
- `rsp_err` out 1: 1 means timeout or rejected mode.
- `rsp_candidate` out 8: result; 0 when `rsp_err`=1.
- `err_cnt` out 8: saturating count of error responses.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Grant when (`req0` | `req1`) and `eng_busy`=0.
  - If both are requesting, grant the requester ≠ `last_id`; otherwise grant the sole requester.
  - On grant, capture that requester's fields into the `eng_*` registers, set `cur_id` and `last_id` to the granted ID, and go to ISSUE.
  - No grant while `eng_busy`=1.
- **ISSUE (exactly 1 cycle):**
  - `ack[cur_id]`=1.
  - If the captured mode≠3: `eng_en`=1, clear the timeout counter, go to WAIT.
  - If mode=3: `eng_en` stays 0; set error result, go to RESP.
- **WAIT:**
  - `eng_valid`=1: capture `eng_candidate`, `err`=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, set candidate=0, `err`=1, go to RESP.
  - `eng_valid` in the same cycle as expiry: valid wins, no error.
- **RESP (1 cycle):**
  - `rsp_valid`=1 with `rsp_id`=`cur_id`, `rsp_err`, and `rsp_candidate`.
  - If `err`=1 and `err_cnt`<255, increment `err_cnt`.
  - Go to IDLE.
- `eng_valid` outside WAIT is ignored, including stray results after a timeout.
- Requesters must drop `reqN` on the edge ending their ack cycle. A request still high in IDLE is treated as a new job.
- Counter width: ceil(log2(TIMEOUT+1)) bits. `err_cnt` saturates at 255 and never wraps.

## Timing
- Reset (synchronous):
  - state=IDLE, `last_id`=1 (so `req0` wins the first contention), counter=0.
  - All outputs 0: `ack*`, `eng_en`, `eng_*` fields, `rsp_*`, `err_cnt`.
- Reset asserted mid-job: IDLE on the next edge. No response is emitted for the aborted job, and `eng_en`/`ack` are not asserted after reset.
- Grant decided in IDLE cycle T. `ackN` and `eng_en` are both high in cycle T+1, with `eng_*` fields valid in T+1.
- `eng_valid` at WAIT cycle V gives `rsp_valid` in V+1.
- The earliest next grant decision is V+2, so the earliest next `eng_en` is V+3.
- Timeout: with no `eng_valid`, WAIT lasts TIMEOUT cycles, then RESP. `eng_en` at cycle E gives an error response at E+TIMEOUT+1.
- Rejected mode 3: grant at T, ack at T+1, `rsp_valid` at T+2. The engine sees no `eng_en`.
- Single outstanding job: `eng_en` is never asserted between an issue and its RESP.

## Test plan
- **Single job:**
  - Stimulus: `req0` with central=24'h440000, radius=12'h300, mode=0; engine model returns 29 three cycles after `en`.
  - Required: `ack0` together with `eng_en` one cycle after the grant, then `rsp_valid` with id=0, err=0, candidate=29.
- **Contention:**
  - Stimulus: `req0` and `req1` both high after reset, then re-requested back-to-back.
  - Required: grant order 0, 1, 0, 1; `rsp_id` alternates; no overlapping `eng_en`.
- **Busy gating:**
  - Stimulus: `eng_busy`=1 for 10 cycles while `req1` is high.
  - Required: no `ack1` or `eng_en` during those 10 cycles; `ack1` the cycle after the first IDLE cycle with busy=0.
- **Timeout:**
  - Stimulus: TIMEOUT=4, engine never answers.
  - Required: `rsp_valid` with err=1, candidate=0 at `eng_en` cycle + 5; `err_cnt`=1.
  - Follow-up: a late stray `eng_valid` causes no second response.
  - Boundary: `eng_valid` on the 4th WAIT cycle yields err=0.
- **Mode 3 and saturation:**
  - Stimulus: `req0` with mode=3.
  - Required: ack, no `eng_en`, error response 2 cycles after the grant.
  - Stimulus: 260 rejected jobs.
  - Required: `err_cnt` holds at 255.
- **Reset mid-WAIT:**
  - Stimulus: `rst` pulsed during WAIT.
  - Required: no `rsp_valid`; all outputs 0 on the next edge; a new `req0` is served normally.

Source files
------------

// File: rtl/set_job_sched.sv
// Round-robin scheduler sharing one SET candidate-counting engine between two
// requesters; results come back tagged with the requester ID, with timeout and mode-3 rejection.
module set_job_sched #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [23:0] central0,
    input  logic [23:0] central1,
    input  logic [11:0] radius0,
    input  logic [11:0] radius1,
    input  logic [1:0]  mode0,
    input  logic [1:0]  mode1,
    output logic        ack0,
    output logic        ack1,
    input  logic        eng_busy,
    output logic        eng_en,
    output logic [23:0] eng_central,
    output logic [11:0] eng_radius,
    output logic [1:0]  eng_mode,
    input  logic        eng_valid,
    input  logic [7:0]  eng_candidate,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic        rsp_err,
    output logic [7:0]  rsp_candidate,
    output logic [7:0]  err_cnt
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [1:0] MODE_REJECT = 2'd3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]    state;
    logic          cur_id;
    logic          last_id;
    logic [CW-1:0] cnt;

    logic          grant;
    logic          grant_id;
    logic [23:0]   sel_central;
    logic [11:0]   sel_radius;
    logic [1:0]    sel_mode;

    // With both requesting, the one not served last wins; otherwise the sole requester.
    always_comb begin
        grant    = (state == S_IDLE) && (req0 || req1) && !eng_busy;
        grant_id = (req0 && req1) ? ~last_id : req1;
        if (grant_id) begin
            sel_central = central1;
            sel_radius  = radius1;
            sel_mode    = mode1;
        end else begin
            sel_central = central0;
            sel_radius  = radius0;
            sel_mode    = mode0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cur_id        <= 1'b0;
            last_id       <= 1'b1;
            cnt           <= '0;
            ack0          <= 1'b0;
            ack1          <= 1'b0;
            eng_en        <= 1'b0;
            eng_central   <= '0;
            eng_radius    <= '0;
            eng_mode      <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_candidate <= '0;
            err_cnt       <= '0;
        end else begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            eng_en    <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        eng_central <= sel_central;
                        eng_radius  <= sel_radius;
                        eng_mode    <= sel_mode;
                        cur_id      <= grant_id;
                        last_id     <= grant_id;
                        ack0        <= ~grant_id;
                        ack1        <= grant_id;
                        // Strobe registered here so it lines up with the ack in ISSUE.
                        eng_en      <= (sel_mode != MODE_REJECT);
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (eng_mode != MODE_REJECT) begin
                        cnt   <= '0;
                        state <= S_WAIT;
                    end else begin
                        rsp_valid     <= 1'b1;
                        rsp_id        <= cur_id;
                        rsp_err       <= 1'b1;
                        rsp_candidate <= '0;
                        state         <= S_RESP;
                    end
                end
                S_WAIT: begin
                    if (eng_valid) begin
                        rsp_valid     <= 1'b1;
                        rsp_id        <= cur_id;
                        rsp_err       <= 1'b0;
                        rsp_candidate <= eng_candidate;
                        state         <= S_RESP;
                    end else if (cnt == CNT_LAST) begin
                        cnt           <= cnt + CW'(1);
                        rsp_valid     <= 1'b1;
                        rsp_id        <= cur_id;
                        rsp_err       <= 1'b1;
                        rsp_candidate <= '0;
                        state         <= S_RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_err && (err_cnt != 8'hFF)) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                    rsp_id        <= 1'b0;
                    rsp_err       <= 1'b0;
                    rsp_candidate <= '0;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_set_job_sched.sv
// Directed bench for set_job_sched (TIMEOUT=4): each task drives one scenario
// cycle by cycle and compares the outputs against hand-computed values.
module tb_set_job_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [23:0] central0 = '0, central1 = '0;
    logic [11:0] radius0 = '0, radius1 = '0;
    logic [1:0]  mode0 = '0, mode1 = '0;
    logic        ack0, ack1;
    logic        eng_busy = 1'b0;
    logic        eng_en;
    logic [23:0] eng_central;
    logic [11:0] eng_radius;
    logic [1:0]  eng_mode;
    logic        eng_valid = 1'b0;
    logic [7:0]  eng_candidate = '0;
    logic        rsp_valid, rsp_id, rsp_err;
    logic [7:0]  rsp_candidate;
    logic [7:0]  err_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [59:0] all_outs;
    assign all_outs = {ack0, ack1, eng_en, eng_central, eng_radius, eng_mode,
                       rsp_valid, rsp_id, rsp_err, rsp_candidate, err_cnt};

    set_job_sched #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .central0(central0), .central1(central1),
        .radius0(radius0), .radius1(radius1),
        .mode0(mode0), .mode1(mode1),
        .ack0(ack0), .ack1(ack1),
        .eng_busy(eng_busy), .eng_en(eng_en),
        .eng_central(eng_central), .eng_radius(eng_radius), .eng_mode(eng_mode),
        .eng_valid(eng_valid), .eng_candidate(eng_candidate),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .rsp_candidate(rsp_candidate), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are then read 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (all_outs !== 60'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", all_outs);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_job();
        req0 = 1'b1; central0 = 24'h440000; radius0 = 12'h300; mode0 = 2'd0;
        tick();
        n_cmp++;
        if ({ack0, ack1, eng_en} !== 3'b101) begin
            n_bad++;
            $display("FAIL single_issue: ack0,ack1,en got %b want 101", {ack0, ack1, eng_en});
        end
        n_cmp++;
        if ({eng_central, eng_radius, eng_mode} !== {24'h440000, 12'h300, 2'd0}) begin
            n_bad++;
            $display("FAIL single_fields: got %h %h %h want 440000 300 0", eng_central, eng_radius, eng_mode);
        end
        req0 = 1'b0;
        tick();
        n_cmp++;
        if ({ack0, eng_en} !== 2'b00) begin
            n_bad++;
            $display("FAIL single_ack_pulse: ack0,en got %b want 00", {ack0, eng_en});
        end
        tick();
        tick();
        eng_valid = 1'b1; eng_candidate = 8'd29;
        tick();
        eng_valid = 1'b0;
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_candidate} !== {3'b100, 8'd29}) begin
            n_bad++;
            $display("FAIL single_rsp: v,id,err,cand got %b%b%b %0d want 100 29", rsp_valid, rsp_id, rsp_err, rsp_candidate);
        end
        tick();
        n_cmp++;
        if ({rsp_valid, err_cnt} !== 9'd0) begin
            n_bad++;
            $display("FAIL single_after: rsp_valid %b err_cnt %0d want 0 0", rsp_valid, err_cnt);
        end
    endtask

    task automatic test_contention();
        logic exp_id;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        central0 = 24'h000AAA; central1 = 24'h000BBB; mode0 = 2'd1; mode1 = 2'd2;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_id = (i % 2 == 1);
            tick();
            n_cmp++;
            if ({ack0, ack1, eng_en} !== {~exp_id, exp_id, 1'b1}) begin
                n_bad++;
                $display("FAIL contention_grant%0d: ack0,ack1,en got %b want %b", i, {ack0, ack1, eng_en}, {~exp_id, exp_id, 1'b1});
            end
            n_cmp++;
            if (eng_central !== (exp_id ? 24'h000BBB : 24'h000AAA)) begin
                n_bad++;
                $display("FAIL contention_central%0d: got %h", i, eng_central);
            end
            if (exp_id) req1 = 1'b0; else req0 = 1'b0;
            tick();
            eng_valid = 1'b1; eng_candidate = 8'(10 + i);
            n_cmp++;
            if ({ack0, ack1, eng_en} !== 3'b000) begin
                n_bad++;
                $display("FAIL contention_overlap%0d: ack0,ack1,en got %b want 000", i, {ack0, ack1, eng_en});
            end
            tick();
            eng_valid = 1'b0;
            n_cmp++;
            if ({rsp_valid, rsp_id, rsp_err, rsp_candidate} !== {1'b1, exp_id, 1'b0, 8'(10 + i)}) begin
                n_bad++;
                $display("FAIL contention_rsp%0d: v,id,err got %b%b%b cand %0d want id %b cand %0d", i, rsp_valid, rsp_id, rsp_err, rsp_candidate, exp_id, 10 + i);
            end
            req0 = 1'b1; req1 = 1'b1;
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    task automatic test_busy_gating();
        eng_busy = 1'b1;
        req1 = 1'b1; central1 = 24'h123456; mode1 = 2'd1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if ({ack0, ack1, eng_en} !== 3'b000) begin
                n_bad++;
                $display("FAIL busy_hold%0d: ack0,ack1,en got %b want 000", i, {ack0, ack1, eng_en});
            end
        end
        eng_busy = 1'b0;
        tick();
        n_cmp++;
        if ({ack0, ack1, eng_en} !== 3'b011) begin
            n_bad++;
            $display("FAIL busy_release: ack0,ack1,en got %b want 011", {ack0, ack1, eng_en});
        end
        req1 = 1'b0;
        tick();
        eng_valid = 1'b1; eng_candidate = 8'd77;
        tick();
        eng_valid = 1'b0;
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_candidate} !== {3'b110, 8'd77}) begin
            n_bad++;
            $display("FAIL busy_rsp: v,id,err got %b%b%b cand %0d want 110 77", rsp_valid, rsp_id, rsp_err, rsp_candidate);
        end
        tick();
    endtask

    task automatic test_timeout();
        req0 = 1'b1; mode0 = 2'd2;
        tick();
        n_cmp++;
        if (eng_en !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_issue: eng_en got %b want 1", eng_en);
        end
        req0 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++;
            if (rsp_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL timeout_early%0d: rsp_valid got %b want 0", i, rsp_valid);
            end
        end
        tick();
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_candidate} !== {3'b101, 8'd0}) begin
            n_bad++;
            $display("FAIL timeout_rsp: v,id,err got %b%b%b cand %0d want 101 0", rsp_valid, rsp_id, rsp_err, rsp_candidate);
        end
        tick();
        n_cmp++;
        if (err_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL timeout_errcnt: got %0d want 1", err_cnt);
        end
        eng_valid = 1'b1; eng_candidate = 8'd55;
        tick();
        eng_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({rsp_valid, ack0, ack1, eng_en} !== 4'b0000) begin
                n_bad++;
                $display("FAIL timeout_stray%0d: v,ack0,ack1,en got %b want 0000", i, {rsp_valid, ack0, ack1, eng_en});
            end
        end
        // Answer lands on the last WAIT cycle, where expiry would otherwise fire.
        req0 = 1'b1; mode0 = 2'd0;
        tick();
        req0 = 1'b0;
        tick();
        tick();
        tick();
        tick();
        eng_valid = 1'b1; eng_candidate = 8'd99;
        tick();
        eng_valid = 1'b0;
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_candidate} !== {2'b10, 8'd99}) begin
            n_bad++;
            $display("FAIL timeout_boundary: v,err got %b%b cand %0d want 10 99", rsp_valid, rsp_err, rsp_candidate);
        end
        tick();
        n_cmp++;
        if (err_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL timeout_boundary_errcnt: got %0d want 1", err_cnt);
        end
    endtask

    task automatic test_mode3();
        req0 = 1'b1; mode0 = 2'd3;
        tick();
        n_cmp++;
        if ({ack0, ack1, eng_en} !== 3'b100) begin
            n_bad++;
            $display("FAIL mode3_issue: ack0,ack1,en got %b want 100", {ack0, ack1, eng_en});
        end
        req0 = 1'b0;
        tick();
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_err, eng_en, rsp_candidate} !== {4'b1010, 8'd0}) begin
            n_bad++;
            $display("FAIL mode3_rsp: v,id,err,en got %b%b%b%b cand %0d want 1010 0", rsp_valid, rsp_id, rsp_err, eng_en, rsp_candidate);
        end
        tick();
        n_cmp++;
        if (err_cnt !== 8'd2) begin
            n_bad++;
            $display("FAIL mode3_errcnt: got %0d want 2", err_cnt);
        end
    endtask

    task automatic test_saturation();
        mode0 = 2'd3;
        for (int i = 1; i <= 260; i++) begin
            req0 = 1'b1;
            tick();
            req0 = 1'b0;
            tick();
            tick();
            if (i == 252) begin
                n_cmp++;
                if (err_cnt !== 8'd254) begin
                    n_bad++;
                    $display("FAIL sat_254: err_cnt got %0d want 254", err_cnt);
                end
            end
            if (i == 253 || i == 260) begin
                n_cmp++;
                if (err_cnt !== 8'd255) begin
                    n_bad++;
                    $display("FAIL sat_hold%0d: err_cnt got %0d want 255", i, err_cnt);
                end
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        req0 = 1'b1; mode0 = 2'd0; central0 = 24'h00C0DE; radius0 = 12'h0AB;
        tick();
        req0 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if (all_outs !== 60'd0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %h want 0", all_outs);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({rsp_valid, ack0, ack1, eng_en} !== 4'b0000) begin
            n_bad++;
            $display("FAIL midreset_quiet: v,ack0,ack1,en got %b want 0000", {rsp_valid, ack0, ack1, eng_en});
        end
        req0 = 1'b1; central0 = 24'h654321; mode0 = 2'd1;
        tick();
        n_cmp++;
        if ({ack0, eng_en, eng_central, eng_mode} !== {2'b11, 24'h654321, 2'd1}) begin
            n_bad++;
            $display("FAIL midreset_issue: ack0,en %b%b central %h mode %0d", ack0, eng_en, eng_central, eng_mode);
        end
        req0 = 1'b0;
        tick();
        eng_valid = 1'b1; eng_candidate = 8'd42;
        tick();
        eng_valid = 1'b0;
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_candidate} !== {3'b100, 8'd42}) begin
            n_bad++;
            $display("FAIL midreset_rsp: v,id,err got %b%b%b cand %0d want 100 42", rsp_valid, rsp_id, rsp_err, rsp_candidate);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_contention();
        test_busy_gating();
        test_timeout();
        test_mode3();
        test_saturation();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
